// File: rtl/vc_arb_ctrl.sv
// Arbitration/routing controller between source FIFOs VC0/VC1 and destination FIFOs D0/D1.
// Define VC_ARB_RR_EN for round-robin VC arbitration; otherwise VC0 has strict priority.
module vc_arb_ctrl #(
   parameter int data_width   = 6,
   parameter int umbral_width = 4,
   parameter int route_bit    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    init,
   input  logic [umbral_width-1:0] umbral_vc_in,
   input  logic [umbral_width-1:0] umbral_d_in,
   input  logic                    vc0_empty,
   input  logic                    vc1_empty,
   input  logic [data_width-1:0]   vc0_data,
   input  logic [data_width-1:0]   vc1_data,
   input  logic                    d0_almost_full,
   input  logic                    d1_almost_full,
   input  logic                    fifo_error,
   output logic                    fifo_init,
   output logic [umbral_width-1:0] umbral_vc,
   output logic [umbral_width-1:0] umbral_d,
   output logic                    pop_vc0,
   output logic                    pop_vc1,
   output logic                    push_d0,
   output logic                    push_d1,
   output logic [data_width-1:0]   data_out,
   output logic [2:0]              state,
   output logic                    idle
);

   typedef enum logic [2:0] {
      ST_RESET  = 3'd0,
      ST_INIT   = 3'd1,
      ST_IDLE   = 3'd2,
      ST_ACTIVE = 3'd3,
      ST_ERROR  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic                  v1;
   logic                  src_q;
   logic                  in_flight;
   logic                  pop_ok;
   logic                  sel_vc1;
   logic [data_width-1:0] word;

   assign state     = state_q;
   assign in_flight = v1 | push_d0 | push_d1;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_RESET;
      else       state_q <= state_d;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d   = state_q;
      fifo_init = 1'b0;
      idle      = 1'b0;
      case (state_q)
         ST_RESET: state_d = ST_INIT;
         ST_INIT:  if (!init) state_d = ST_IDLE;
         ST_IDLE: begin
            fifo_init = 1'b1;
            idle      = 1'b1;
            if (fifo_error)                 state_d = ST_ERROR;
            else if (init)                  state_d = ST_INIT;
            else if (!vc0_empty || !vc1_empty) state_d = ST_ACTIVE;
         end
         ST_ACTIVE: begin
            fifo_init = 1'b1;
            if (fifo_error)                                    state_d = ST_ERROR;
            else if (vc0_empty && vc1_empty && !in_flight)     state_d = ST_IDLE;
         end
         ST_ERROR: fifo_init = 1'b1;
         default:  state_d = ST_RESET;
      endcase
   end

   // Destination is unknown until the word is read, so either almost-full blocks all pops.
   assign pop_ok = (state_q == ST_ACTIVE) && !fifo_error && !d0_almost_full && !d1_almost_full;

`ifdef VC_ARB_RR_EN
   logic last_vc1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                  last_vc1 <= 1'b1;
      else if (pop_vc0 || pop_vc1) last_vc1 <= pop_vc1;
   end

   assign sel_vc1 = !vc1_empty && (vc0_empty || !last_vc1);
`else
   assign sel_vc1 = vc0_empty && !vc1_empty;
`endif

   assign pop_vc1 = pop_ok && sel_vc1;
   assign pop_vc0 = pop_ok && !vc0_empty && !sel_vc1;

   assign word = src_q ? vc1_data : vc0_data;

   // Two-stage pipeline: pop -> source FIFO read data -> registered push.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         v1       <= 1'b0;
         src_q    <= 1'b0;
         push_d0  <= 1'b0;
         push_d1  <= 1'b0;
         data_out <= '0;
      end else begin
         v1 <= pop_vc0 || pop_vc1;
         if (pop_vc0 || pop_vc1) src_q <= pop_vc1;
         push_d0 <= v1 && !word[route_bit];
         push_d1 <= v1 &&  word[route_bit];
         if (v1) data_out <= word;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         umbral_vc <= '0;
         umbral_d  <= '0;
      end else if (state_q == ST_INIT && init) begin
         umbral_vc <= umbral_vc_in;
         umbral_d  <= umbral_d_in;
      end
   end

endmodule

// File: tb/tb_vc_arb_ctrl.sv
// Self-checking bench for vc_arb_ctrl: FIFO models, expected-word scoreboard and pop-order queue.
module tb_vc_arb_ctrl;
   localparam int DW = 6;
   localparam int UW = 4;
   localparam int RB = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          init = 1'b0;
   logic [UW-1:0] umbral_vc_in = '0;
   logic [UW-1:0] umbral_d_in = '0;
   logic          vc0_empty = 1'b1;
   logic          vc1_empty = 1'b1;
   logic [DW-1:0] vc0_data = '0;
   logic [DW-1:0] vc1_data = '0;
   logic          d0_almost_full = 1'b0;
   logic          d1_almost_full = 1'b0;
   logic          fifo_error = 1'b0;
   logic          fifo_init;
   logic [UW-1:0] umbral_vc, umbral_d;
   logic          pop_vc0, pop_vc1, push_d0, push_d1;
   logic [DW-1:0] data_out;
   logic [2:0]    state;
   logic          idle;

   vc_arb_ctrl #(.data_width(DW), .umbral_width(UW), .route_bit(RB)) dut (
      .clk(clk), .reset(reset), .init(init),
      .umbral_vc_in(umbral_vc_in), .umbral_d_in(umbral_d_in),
      .vc0_empty(vc0_empty), .vc1_empty(vc1_empty),
      .vc0_data(vc0_data), .vc1_data(vc1_data),
      .d0_almost_full(d0_almost_full), .d1_almost_full(d1_almost_full),
      .fifo_error(fifo_error), .fifo_init(fifo_init),
      .umbral_vc(umbral_vc), .umbral_d(umbral_d),
      .pop_vc0(pop_vc0), .pop_vc1(pop_vc1),
      .push_d0(push_d0), .push_d1(push_d1),
      .data_out(data_out), .state(state), .idle(idle)
   );

   always #5 clk = ~clk;

   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   int            n_pop = 0;
   int            n_push = 0;
   logic [DW-1:0] q0[$];
   logic [DW-1:0] q1[$];
   logic [DW-1:0] sb[$];
   int            exp_pop[$];
   int            pop_cyc_q[$];
   int            push_cyc_q[$];
   int            base_pop, base_push;

`ifdef VC_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Source FIFO model: read data valid the cycle after a pop; cleared while fifo_init is low.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!fifo_init) begin
         q0.delete();
         q1.delete();
      end else begin
         if (pop_vc0 && q0.size() > 0) begin
            vc0_data <= q0[0];
            q0.delete(0);
         end
         if (pop_vc1 && q1.size() > 0) begin
            vc1_data <= q1[0];
            q1.delete(0);
         end
      end
      vc0_empty <= (q0.size() == 0);
      vc1_empty <= (q1.size() == 0);
   end

   // Output monitor, sampled on the falling edge.
   always @(negedge clk) begin
      logic [DW-1:0] e;
      int            pc;
      if (!reset) begin
         if (pop_vc0 || pop_vc1) begin
            n_pop++;
            if (pop_vc0 && pop_vc1) check("pop_both", 32'd1, 32'd0);
            if ((pop_vc0 && vc0_empty) || (pop_vc1 && vc1_empty)) check("pop_empty", 32'd1, 32'd0);
            if (d0_almost_full || d1_almost_full) check("pop_under_af", 32'd1, 32'd0);
            if (exp_pop.size() == 0) check("pop_unexpected", 32'(pop_vc1), 32'hFF);
            else check("pop_order", 32'(pop_vc1), 32'(exp_pop.pop_front()));
            pop_cyc_q.push_back(cyc);
         end
         if (push_d0 || push_d1) begin
            n_push++;
            push_cyc_q.push_back(cyc);
            if (sb.size() == 0) check("push_unexpected", 32'(data_out), 32'hFF);
            else begin
               e = sb.pop_front();
               check("push_dest", 32'({push_d1, push_d0}), 32'({e[RB], ~e[RB]}));
               check("data_out", 32'(data_out), 32'(e));
               pc = (pop_cyc_q.size() > 0) ? pop_cyc_q.pop_front() : -100;
               check("push_latency", 32'(cyc - pc), 32'd2);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, time %0t", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input int vc, input logic [DW-1:0] w);
      if (vc == 0) q0.push_back(w);
      else         q1.push_back(w);
   endtask

   // Expected grant order for freshly loaded queues (both loaded together, last grant = VC1).
   task automatic plan();
      int i0 = 0, i1 = 0;
      bit last1 = 1'b1;
      bit take1;
      while (i0 < q0.size() || i1 < q1.size()) begin
         take1 = (i1 < q1.size()) && ((i0 >= q0.size()) || (RR && !last1));
         if (take1) begin sb.push_back(q1[i1]); exp_pop.push_back(1); i1++; end
         else       begin sb.push_back(q0[i0]); exp_pop.push_back(0); i0++; end
         last1 = take1;
      end
   endtask

   task automatic wait_pop(input int max);
      bit seen = 1'b0;
      for (int i = 0; i < max && !seen; i++) begin
         @(negedge clk);
         if (pop_vc0 || pop_vc1) seen = 1'b1;
      end
      check("wait_pop", 32'(seen), 32'd1);
   endtask

   task automatic wait_drain(input int max);
      bit done = 1'b0;
      for (int i = 0; i < max && !done; i++) begin
         @(negedge clk);
         if (sb.size() == 0 && state == 3'd2) done = 1'b1;
      end
      check("drain_sb", 32'(sb.size()), 32'd0);
      check("drain_idle", 32'(state), 32'd2);
   endtask

   task automatic reinit();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      init = 1'b1;
      repeat (3) tick();
      init = 1'b0;
      tick();
      tick();
      @(negedge clk);
      check("reinit_idle", 32'(state), 32'd2);
   endtask

   initial begin
      // Reset and configuration
      init = 1'b1;
      umbral_vc_in = 4'd1;
      umbral_d_in = 4'd3;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_state", 32'(state), 32'd0);
      check("rst_ctrl", 32'({fifo_init, idle, pop_vc0, pop_vc1, push_d0, push_d1}), 32'd0);
      check("rst_umbral", 32'({umbral_vc, umbral_d}), 32'd0);
      check("rst_data", 32'(data_out), 32'd0);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("cfg_hold_reset", 32'(state), 32'd0);
      tick();
      @(negedge clk);
      check("cfg_init_state", 32'(state), 32'd1);
      check("cfg_init_fifo_init", 32'(fifo_init), 32'd0);
      tick();
      tick();
      @(negedge clk);
      check("cfg_umbral_vc", 32'(umbral_vc), 32'd1);
      check("cfg_umbral_d", 32'(umbral_d), 32'd3);
      tick();
      init = 1'b0;
      umbral_vc_in = 4'd7;
      umbral_d_in = 4'd9;
      @(negedge clk);
      check("cfg_still_init", 32'(state), 32'd1);
      tick();
      @(negedge clk);
      check("cfg_idle_state", 32'(state), 32'd2);
      check("cfg_idle_flags", 32'({fifo_init, idle}), 32'b11);
      check("cfg_umbral_held", 32'({umbral_vc, umbral_d}), 32'h13);

      // Arbitration: three words in each VC
      tick();
      load(0, 6'h15); load(0, 6'h03); load(0, 6'h1A);
      load(1, 6'h2C); load(1, 6'h11); load(1, 6'h06);
      plan();
      push_cyc_q.delete();
      wait_drain(40);
      check("prio_push_count", 32'(push_cyc_q.size()), 32'd6);
      if (push_cyc_q.size() == 6)
         check("prio_back_to_back", 32'(push_cyc_q[5] - push_cyc_q[0]), 32'd5);

      // Single word routed to D1
      tick();
      load(0, 6'b010101);
      sb.push_back(6'h15);
      exp_pop.push_back(0);
      wait_drain(20);
      check("single_idle", 32'({state, idle}), 32'({3'd2, 1'b1}));

      // Backpressure
      tick();
      d0_almost_full = 1'b1;
      load(0, 6'h01); load(0, 6'h12); load(0, 6'h23); load(0, 6'h34); load(0, 6'h05);
      plan();
      base_pop = n_pop;
      repeat (6) @(negedge clk);
      check("bp_no_pop", 32'(n_pop - base_pop), 32'd0);
      check("bp_active", 32'(state), 32'd3);
      tick();
      d0_almost_full = 1'b0;
      @(negedge clk);
      check("bp_resume", 32'(pop_vc0), 32'd1);
      tick();
      d0_almost_full = 1'b1;
      base_push = n_push;
      repeat (6) @(negedge clk);
      check("bp_land_le2", 32'((n_push - base_push) <= 2), 32'd1);
      tick();
      d0_almost_full = 1'b0;
      wait_drain(40);

      // Error with one word in flight
      tick();
      load(0, 6'h3B);
      sb.push_back(6'h3B);
      exp_pop.push_back(0);
      wait_pop(20);
      tick();
      fifo_error = 1'b1;
      load(0, 6'h01);
      load(0, 6'h02);
      base_pop = n_pop;
      tick();
      @(negedge clk);
      check("err_state", 32'(state), 32'd4);
      repeat (5) @(negedge clk);
      check("err_drained", 32'(sb.size()), 32'd0);
      check("err_fifo_init", 32'(fifo_init), 32'd1);
      tick();
      init = 1'b1;
      repeat (3) @(negedge clk);
      check("err_sticky", 32'(state), 32'd4);
      check("err_no_pop", 32'(n_pop - base_pop), 32'd0);
      tick();
      #2 reset = 1'b1;
      #1 check("err_reset_state", 32'(state), 32'd0);
      fifo_error = 1'b0;
      init = 1'b0;
      reinit();

      // Asynchronous reset mid-stream
      tick();
      load(0, 6'h21); load(0, 6'h12); load(0, 6'h33); load(0, 6'h04);
      load(1, 6'h15); load(1, 6'h26);
      plan();
      wait_pop(20);
      @(posedge clk);
      #3 reset = 1'b1;
      #1;
      check("ar_state", 32'(state), 32'd0);
      check("ar_ctrl", 32'({fifo_init, idle, pop_vc0, pop_vc1, push_d0, push_d1}), 32'd0);
      check("ar_data", 32'(data_out), 32'd0);
      check("ar_umbral", 32'({umbral_vc, umbral_d}), 32'd0);
      sb.delete();
      exp_pop.delete();
      pop_cyc_q.delete();
      base_push = n_push;
      base_pop = n_pop;
      reinit();
      repeat (6) @(negedge clk);
      check("ar_no_stray_push", 32'(n_push - base_push), 32'd0);
      check("ar_no_stray_pop", 32'(n_pop - base_pop), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
